// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with operand forwarding, load-use bubble, flush and hold.
// Define ID_EX_PERF_CNT_EN to add the o_lu_bubbles / o_flushes event counters.
module id_ex_pipe #(
   parameter int CTRL_W = 16,
   parameter int XLEN   = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid_D,
   input  logic [XLEN-1:0]   i_pc_D,
   input  logic [XLEN-1:0]   i_rs1_data_D,
   input  logic [XLEN-1:0]   i_rs2_data_D,
   input  logic [XLEN-1:0]   i_imm_D,
   input  logic [4:0]        i_rs1_addr_D,
   input  logic [4:0]        i_rs2_addr_D,
   input  logic [4:0]        i_rd_addr_D,
   input  logic              i_rd_wren_D,
   input  logic              i_mem_rden_D,
   input  logic [CTRL_W-1:0] i_ctrl_D,
   input  logic [1:0]        i_ForwardA,
   input  logic [1:0]        i_ForwardB,
   input  logic [XLEN-1:0]   i_alu_data_M,
   input  logic [XLEN-1:0]   i_wb_data_W,
   input  logic              i_flush_E,
   input  logic              i_stall_E,
   output logic              o_stall_D,
   output logic              o_valid_E,
   output logic [XLEN-1:0]   o_pc_E,
   output logic [XLEN-1:0]   o_rs1_data_E,
   output logic [XLEN-1:0]   o_rs2_data_E,
   output logic [XLEN-1:0]   o_imm_E,
   output logic [4:0]        o_rs1_addr_E,
   output logic [4:0]        o_rs2_addr_E,
   output logic [4:0]        o_rd_addr_E,
   output logic              o_rd_wren_E,
   output logic              o_mem_rden_E,
`ifdef ID_EX_PERF_CNT_EN
   output logic [31:0]       o_lu_bubbles,
   output logic [31:0]       o_flushes,
`endif
   output logic [CTRL_W-1:0] o_ctrl_E
);
   logic [XLEN-1:0] op_a, op_b;
   logic            lu;
   assign op_a = i_ForwardA == 2'b10 ? i_alu_data_M : i_ForwardA == 2'b01 ? i_wb_data_W : i_rs1_data_D;
   assign op_b = i_ForwardB == 2'b10 ? i_alu_data_M : i_ForwardB == 2'b01 ? i_wb_data_W : i_rs2_data_D;
   // Bubbles never carry mem_rden, so a load-use stall cannot repeat on itself
   assign lu = o_valid_E & o_mem_rden_E & o_rd_wren_E & (o_rd_addr_E != 5'd0) & i_valid_D &
               (o_rd_addr_E == i_rs1_addr_D | o_rd_addr_E == i_rs2_addr_D);
   assign o_stall_D = (lu | i_stall_E) & ~i_flush_E;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         o_valid_E    <= 1'b0;
         o_pc_E       <= '0;
         o_rs1_data_E <= '0;
         o_rs2_data_E <= '0;
         o_imm_E      <= '0;
         o_rs1_addr_E <= '0;
         o_rs2_addr_E <= '0;
         o_rd_addr_E  <= '0;
         o_rd_wren_E  <= 1'b0;
         o_mem_rden_E <= 1'b0;
         o_ctrl_E     <= '0;
      end else if (i_flush_E || (!i_stall_E && lu)) begin
         o_valid_E    <= 1'b0;
         o_rd_wren_E  <= 1'b0;
         o_mem_rden_E <= 1'b0;
         o_ctrl_E     <= '0;
      end else if (!i_stall_E) begin
         o_valid_E    <= i_valid_D;
         o_pc_E       <= i_pc_D;
         o_rs1_data_E <= op_a;
         o_rs2_data_E <= op_b;
         o_imm_E      <= i_imm_D;
         o_rs1_addr_E <= i_rs1_addr_D;
         o_rs2_addr_E <= i_rs2_addr_D;
         o_rd_addr_E  <= i_rd_addr_D;
         o_rd_wren_E  <= i_rd_wren_D & i_valid_D;
         o_mem_rden_E <= i_mem_rden_D & i_valid_D;
         o_ctrl_E     <= i_ctrl_D;
      end
`ifdef ID_EX_PERF_CNT_EN
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         o_lu_bubbles <= '0;
         o_flushes    <= '0;
      end else begin
         if (!i_flush_E && !i_stall_E && lu) o_lu_bubbles <= o_lu_bubbles + 32'd1;
         if (i_flush_E && i_valid_D) o_flushes <= o_flushes + 32'd1;
      end
`endif
endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

Decode-to-execute pipeline register for the 5-stage pipeline. Applies the ForwardA/ForwardB selects from the forwarding unit to the decode-stage operands, registers the result with decode control into the E stage, and detects load-use hazards. On a load-use hazard it inserts a bubble and stalls decode. It also honours flush requests from branch resolution and hold requests from a stalled execute/memory stage.

## Interface
- CTRL_W, 16: width of opaque decode control bundle (ALU op, branch type, mem size, wb select)
- XLEN, 32: datapath width

- i_clk  in  1  rising-edge clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid_D  in  1  decode slot holds a real instruction
- i_pc_D  in  XLEN  decode PC
- i_rs1_data_D, i_rs2_data_D  in  XLEN  register-file read data
- i_imm_D  in  XLEN  decoded immediate
- i_rs1_addr_D, i_rs2_addr_D, i_rd_addr_D  in  5  register addresses
- i_rd_wren_D, i_mem_rden_D  in  1  writes rd / is a load
- i_ctrl_D  in  CTRL_W  control bundle
- i_ForwardA, i_ForwardB  in  2  forward selects (10 = M, 01 = W, 00/11 = register file)
- i_alu_data_M, i_wb_data_W  in  XLEN  forward sources
- i_flush_E  in  1  squash instruction entering E
- i_stall_E  in  1  downstream hold
- o_stall_D  out  1  freeze PC and IF/ID register
- o_valid_E, o_pc_E, o_rs1_data_E, o_rs2_data_E, o_imm_E, o_rs1_addr_E, o_rs2_addr_E, o_rd_addr_E, o_rd_wren_E, o_mem_rden_E, o_ctrl_E  out  as D counterparts  registered E-stage fields

## Operation
- Operand select (combinational): opA = ForwardA 10 → i_alu_data_M; 01 → i_wb_data_W; else → i_rs1_data_D. opB uses ForwardB and rs2 the same way.
- Load-use: lu = o_valid_E & o_mem_rden_E & o_rd_wren_E & (o_rd_addr_E != 0) & i_valid_D & (o_rd_addr_E == i_rs1_addr_D | o_rd_addr_E == i_rs2_addr_D).
- o_stall_D = (lu | i_stall_E) & ~i_flush_E.
- Register update, per rising edge, in priority order:
  1. i_flush_E: load bubble.
  2. i_stall_E: hold all E fields.
  3. lu: load bubble. Decode is held by o_stall_D and recaptured next cycle with W forwarding.
  4. Otherwise: capture D fields, opA, and opB. o_valid_E = i_valid_D.
- Bubble: o_valid_E = 0, o_rd_wren_E = 0, o_mem_rden_E = 0, o_ctrl_E = 0. Data and address fields are don't-care and are held at their previous values.
- When o_valid_E = 0, o_rd_wren_E and o_mem_rden_E are always 0. A capture with i_valid_D = 0 forces both to 0.
- Only o_rd_wren_E and o_mem_rden_E are gated by valid. A bubble is never reported as a load, so lu cannot chain.

## Timing
- Reset (async assert, sync release): all outputs 0, including o_stall_D (combinational, since o_valid_E = 0).
- Latency: D → E is 1 cycle. Forwarded data is sampled in the same cycle as the select.
- A load-use hazard costs exactly one bubble. o_stall_D is high for 1 cycle unless i_stall_E extends it.
- Flush while lu is active: bubble loaded, o_stall_D low, decode advances.
- Flush while i_stall_E is active: flush wins and E becomes a bubble.
- Reset mid-stall: the stall is abandoned and E becomes empty.

## Configuration
- ID_EX_PERF_CNT_EN defined: adds o_lu_bubbles (32) and o_flushes (32).
  - Both reset to 0 and wrap at 2^32.
  - o_lu_bubbles increments on each edge where lu is taken (priority 3).
  - o_flushes increments on each edge where i_flush_E = 1 and the incoming slot is valid (i_valid_D = 1).
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

## Test plan
- Reset: drive i_rst_n = 0 mid-cycle with valid inputs → all outputs 0 immediately. After release, first capture of pc 0x100 appears on o_pc_E 1 cycle later.
- Forwarding: rs1_data = 0x11, M = 0x22, W = 0x33.
  - ForwardA = 10 → o_rs1_data_E = 0x22.
  - ForwardB = 01 → o_rs2_data_E = 0x33.
  - ForwardA = 11 → o_rs1_data_E = 0x11.
- Load-use: lw x5 in E, D = add x6, x5, x1 → o_stall_D = 1 for one cycle, E gets a bubble (valid = 0, rd_wren = 0). The next cycle captures the add.
- Non-hazard: lw x0 in E with D rs1 = x0, or E bubble with rd = 5 → o_stall_D = 0 and no bubble.
- Flush priority: i_flush_E = 1 together with i_stall_E = 1 and an active lu → o_stall_D = 0 and o_valid_E = 0 next edge. The perf counter (if enabled) increments only o_flushes.
- Hold: i_stall_E = 1 for 3 cycles → every E field is unchanged and o_stall_D = 1 for all 3 cycles.
